// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the PS/2 keyboard controller:
//   - PS/2 set-2 scan-code constants (prefixes, command keys, digit keys)
//   - rx_state_t: receiver state, also exported for debug observation
//   - digit_lookup(): maps a digit make code to {hit, value}
// -----------------------------------------------------------------------------
package kbd_pkg;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    localparam logic [7:0] KEY_G      = 8'h34;
    localparam logic [7:0] KEY_P      = 8'h4D;
    localparam logic [7:0] KEY_C      = 8'h21;
    localparam logic [7:0] KEY_M      = 8'h3A;
    localparam logic [7:0] KEY_A      = 8'h1C;
    localparam logic [7:0] KEY_W      = 8'h1D;
    localparam logic [7:0] KEY_S      = 8'h1B;
    localparam logic [7:0] KEY_D      = 8'h23;
    localparam logic [7:0] KEY_SPACE  = 8'h29;

    localparam logic [7:0] DIGIT_0    = 8'h45;
    localparam logic [7:0] DIGIT_1    = 8'h16;
    localparam logic [7:0] DIGIT_2    = 8'h1E;
    localparam logic [7:0] DIGIT_3    = 8'h26;
    localparam logic [7:0] DIGIT_4    = 8'h25;
    localparam logic [7:0] DIGIT_5    = 8'h2E;
    localparam logic [7:0] DIGIT_6    = 8'h36;
    localparam logic [7:0] DIGIT_7    = 8'h3D;
    localparam logic [7:0] DIGIT_8    = 8'h3E;
    localparam logic [7:0] DIGIT_9    = 8'h46;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Returns {1'b1, value} for a digit make code, 5'd0 otherwise.
    function automatic logic [4:0] digit_lookup(input logic [7:0] code);
        case (code)
            DIGIT_0: return {1'b1, 4'd0};
            DIGIT_1: return {1'b1, 4'd1};
            DIGIT_2: return {1'b1, 4'd2};
            DIGIT_3: return {1'b1, 4'd3};
            DIGIT_4: return {1'b1, 4'd4};
            DIGIT_5: return {1'b1, 4'd5};
            DIGIT_6: return {1'b1, 4'd6};
            DIGIT_7: return {1'b1, 4'd7};
            DIGIT_8: return {1'b1, 4'd8};
            DIGIT_9: return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/key_board_controller_if.sv
// -----------------------------------------------------------------------------
// key_board_controller_if
// Bundles the keyboard-side PS/2 lines and the decoded command outputs.
//   ps2_clock, ps2_data : raw asynchronous PS/2 lines (keyboard -> controller)
//   start/pause/clear/modify : one-cycle command pulses
//   setting[3:0]        : one-hot one-cycle pulse (A, W, S, D)
//   manual              : level, toggled by M
//   file_id[15:0]       : level, last digit key value
//   rx_state            : receiver state, for debug observation
// Modports: slave = controller side, master = keyboard/environment side.
// -----------------------------------------------------------------------------
interface key_board_controller_if;
    import kbd_pkg::*;

    logic        ps2_clock;
    logic        ps2_data;
    logic        start;
    logic        pause;
    logic        clear;
    logic        manual;
    logic [3:0]  setting;
    logic        modify;
    logic [15:0] file_id;
    rx_state_t   rx_state;

    modport slave (
        input  ps2_clock, ps2_data,
        output start, pause, clear, manual, setting, modify, file_id, rx_state
    );

    modport master (
        output ps2_clock, ps2_data,
        input  start, pause, clear, manual, setting, modify, file_id, rx_state
    );

endinterface

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 frame receiver: two-flop synchronizers, falling-edge detect on the
// synchronized clock, 11-bit frame capture (start, 8 data LSB first, odd
// parity, stop), inactivity timeout and the code-valid strobe.
// Optional feature macro: KBD_PARITY_CHECK_EN (discard frames with bad parity;
// when undefined the parity bit is consumed and ignored).
// Ports:
//   clk_in, reset        : system clock, synchronous active-high reset
//   ps2_clock, ps2_data  : asynchronous PS/2 lines
//   code_valid, code     : received-code strobe and byte
//   state                : receiver state (debug)
// code_valid is a one-cycle strobe with no back-pressure: the consumer must
// take code in the cycle code_valid is high; code is held until the next frame.
// -----------------------------------------------------------------------------
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       code_valid,
    output logic [7:0] code,
    output rx_state_t  state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;
    logic          frame_ok;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] idle_cnt;

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];

`ifdef KBD_PARITY_CHECK_EN
    logic parity_bit;
    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign frame_ok = bit_in & (^{shift, parity_bit});
`else
    assign frame_ok = bit_in;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            // Lines idle high, so preload the synchronizers high to avoid a
            // false falling edge right after reset.
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            idle_cnt   <= '0;
            code_valid <= 1'b0;
            code       <= 8'd0;
`ifdef KBD_PARITY_CHECK_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clock};
            data_sync  <= {data_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            code_valid <= 1'b0;

            if (state == RX_IDLE || fall) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            if (state != RX_IDLE && !fall && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // Keyboard went quiet mid-frame: drop the partial frame.
                state <= RX_IDLE;
            end else if (fall) begin
                case (state)
                    RX_IDLE: begin
                        // A start bit sampled as 1 is noise; stay idle.
                        if (!bit_in) begin
                            state   <= RX_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {bit_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                        parity_bit <= bit_in;
`endif
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        state <= RX_IDLE;
                        if (frame_ok) begin
                            code_valid <= 1'b1;
                            code       <= shift;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/key_board_controller.sv
// -----------------------------------------------------------------------------
// key_board_controller
// PS/2 keyboard command decoder. Receives scan codes through ps2_rx, tracks the
// break (F0) and extended (E0) prefixes, and turns make codes into registered
// command pulses and levels.
// Optional feature macro: KBD_PARITY_CHECK_EN (handled inside ps2_rx).
// Ports:
//   clk_in, reset : system clock, synchronous active-high reset
//   bus           : key_board_controller_if.slave (PS/2 lines in, commands out)
// Parameter TIMEOUT_CYCLES: clk_in cycles of PS/2 clock inactivity before a
// partial frame is dropped.
// -----------------------------------------------------------------------------
module key_board_controller
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk_in,
    input  logic                   reset,
    key_board_controller_if.slave  bus
);

    logic       code_valid;
    logic [7:0] code;
    logic       brk_pending;
    logic       ext_pending;
    logic [4:0] digit;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_in     (clk_in),
        .reset      (reset),
        .ps2_clock  (bus.ps2_clock),
        .ps2_data   (bus.ps2_data),
        .code_valid (code_valid),
        .code       (code),
        .state      (bus.rx_state)
    );

    assign digit = digit_lookup(code);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            bus.start   <= 1'b0;
            bus.pause   <= 1'b0;
            bus.clear   <= 1'b0;
            bus.manual  <= 1'b0;
            bus.setting <= 4'd0;
            bus.modify  <= 1'b0;
            bus.file_id <= 16'd0;
            brk_pending <= 1'b0;
            ext_pending <= 1'b0;
        end else begin
            bus.start   <= 1'b0;
            bus.pause   <= 1'b0;
            bus.clear   <= 1'b0;
            bus.setting <= 4'd0;
            bus.modify  <= 1'b0;

            if (code_valid) begin
                if (ext_pending) begin
                    // Extended key: swallow an optional F0 and the key code.
                    if (code != CODE_BREAK) begin
                        ext_pending <= 1'b0;
                    end
                end else if (brk_pending) begin
                    brk_pending <= 1'b0;
                end else if (code == CODE_BREAK) begin
                    brk_pending <= 1'b1;
                end else if (code == CODE_EXT) begin
                    ext_pending <= 1'b1;
                end else begin
                    // Only one code per strobe, so at most one pulse fires.
                    case (code)
                        KEY_G:     bus.start   <= 1'b1;
                        KEY_P:     bus.pause   <= 1'b1;
                        KEY_C:     bus.clear   <= 1'b1;
                        KEY_M:     bus.manual  <= ~bus.manual;
                        KEY_A:     bus.setting <= 4'b0001;
                        KEY_W:     bus.setting <= 4'b0010;
                        KEY_S:     bus.setting <= 4'b0100;
                        KEY_D:     bus.setting <= 4'b1000;
                        KEY_SPACE: bus.modify  <= 1'b1;
                        default: begin
                            if (digit[4]) begin
                                bus.file_id <= {12'd0, digit[3:0]};
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_key_board_controller.sv
// -----------------------------------------------------------------------------
// tb_key_board_controller
// Bench for key_board_controller: table of scan codes with expected results,
// hand sequences for frame-level corner cases (bad parity, stray start bit,
// bad stop bit, timeout, mid-frame reset) and random codes checked against a
// table-based reference model. Honours KBD_PARITY_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_key_board_controller;
    import kbd_pkg::*;

    localparam int TB_TIMEOUT = 60;
    localparam int HALF       = 6;
    localparam int NV         = 28;
    localparam int NRAND      = 60;

    typedef struct {
        logic [7:0]  code;
        int          exp_pulse;   // -1 none, else bit index of pulse vector
        logic        exp_manual;
        logic [15:0] exp_fid;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset;

    key_board_controller_if bus ();

    key_board_controller #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int fails  = 0;

    // Pulse monitor; ids: 0 start, 1 pause, 2 clear, 3..6 setting A/W/S/D, 7 modify
    int pulse_total   = 0;
    int overlap_total = 0;
    int last_id       = -1;

    always @(negedge clk_in) begin : monitor
        logic [7:0] pv;
        int n;
        pv = {bus.modify, bus.setting, bus.clear, bus.pause, bus.start};
        n  = 0;
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                if (pv[i]) begin
                    n++;
                    last_id = i;
                end
            end
            pulse_total = pulse_total + n;
            if (n > 1) overlap_total++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          key_action [256];  // -1 ignore, 0..7 pulse id, 8 toggle M, 100+d digit
    logic        m_brk, m_ext, m_manual;
    logic [15:0] m_fid;

    task automatic model_init();
        for (int i = 0; i < 256; i++) key_action[i] = -1;
        key_action[8'h34] = 0;  key_action[8'h4D] = 1;  key_action[8'h21] = 2;
        key_action[8'h1C] = 3;  key_action[8'h1D] = 4;  key_action[8'h1B] = 5;
        key_action[8'h23] = 6;  key_action[8'h29] = 7;  key_action[8'h3A] = 8;
        key_action[8'h45] = 100; key_action[8'h16] = 101; key_action[8'h1E] = 102;
        key_action[8'h26] = 103; key_action[8'h25] = 104; key_action[8'h2E] = 105;
        key_action[8'h36] = 106; key_action[8'h3D] = 107; key_action[8'h3E] = 108;
        key_action[8'h46] = 109;
    endtask

    function automatic int model_step(input logic [7:0] c);
        int a;
        int act;
        act = -1;
        if (m_ext) begin
            if (c != 8'hF0) m_ext = 1'b0;
        end else if (m_brk) begin
            m_brk = 1'b0;
        end else if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else if (c == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            a = key_action[c];
            if (a >= 0 && a <= 7)  act = a;
            else if (a == 8)       m_manual = ~m_manual;
            else if (a >= 100)     m_fid = 16'(a - 100);
        end
        return act;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk_in);
        bus.ps2_clock = 1'b0;
        repeat (HALF) @(negedge clk_in);
        bus.ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic par_good, input logic stop);
        logic par;
        par = ~^c;                 // odd parity bit
        if (!par_good) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit(par);
        ps2_bit(stop);
        bus.ps2_data = 1'b1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] c, input logic par_good,
                             input logic stop, input int exp_pulse, input logic exp_man,
                             input logic [15:0] exp_fid);
        int p0, o0;
        p0 = pulse_total;
        o0 = overlap_total;
        send_frame(c, par_good, stop);
        repeat (6) @(posedge clk_in);
        #1;
        check({name, "_pulses"}, pulse_total - p0, (exp_pulse >= 0) ? 1 : 0);
        if (exp_pulse >= 0) check({name, "_which"}, last_id, exp_pulse);
        check({name, "_overlap"}, overlap_total - o0, 0);
        check({name, "_manual"}, int'(bus.manual), int'(exp_man));
        check({name, "_file_id"}, int'(bus.file_id), int'(exp_fid));
    endtask

    function automatic vec_t mk(input logic [7:0] c, input int p, input logic m, input logic [15:0] f);
        vec_t v;
        v.code = c; v.exp_pulse = p; v.exp_manual = m; v.exp_fid = f;
        return v;
    endfunction

    function automatic int all_outputs();
        return int'({bus.modify, bus.setting, bus.clear, bus.pause, bus.start,
                     bus.manual, bus.file_id});
    endfunction

    vec_t vecs [NV];
    logic [7:0] pool [22] = '{8'hF0, 8'hE0, 8'h34, 8'h4D, 8'h21, 8'h3A, 8'h1C, 8'h1D,
                              8'h1B, 8'h23, 8'h29, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h55};

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        int exp_bad_par;
        int act;
        logic [7:0] c;

        bus.ps2_clock = 1'b1;
        bus.ps2_data  = 1'b1;
        reset = 1'b1;
        model_init();

        vecs = '{
            mk(8'h34,  0, 1'b0, 16'd0),  // G -> start
            mk(8'h3A, -1, 1'b1, 16'd0),  // M -> manual 1
            mk(8'hF0, -1, 1'b1, 16'd0),
            mk(8'h3A, -1, 1'b1, 16'd0),  // break M: unchanged
            mk(8'h3A, -1, 1'b0, 16'd0),  // M -> manual 0
            mk(8'h1D,  4, 1'b0, 16'd0),  // W -> setting 0010
            mk(8'hF0, -1, 1'b0, 16'd0),
            mk(8'h1D, -1, 1'b0, 16'd0),  // break W: no pulse
            mk(8'h26, -1, 1'b0, 16'd3),  // digit 3
            mk(8'hE0, -1, 1'b0, 16'd3),
            mk(8'h26, -1, 1'b0, 16'd3),  // extended: consumed
            mk(8'h4D,  1, 1'b0, 16'd3),  // P -> pause
            mk(8'h21,  2, 1'b0, 16'd3),  // C -> clear
            mk(8'h1C,  3, 1'b0, 16'd3),  // A
            mk(8'h1B,  5, 1'b0, 16'd3),  // S
            mk(8'h23,  6, 1'b0, 16'd3),  // D
            mk(8'h29,  7, 1'b0, 16'd3),  // Space -> modify
            mk(8'h45, -1, 1'b0, 16'd0),  // digit 0
            mk(8'h46, -1, 1'b0, 16'd9),  // digit 9
            mk(8'hE0, -1, 1'b0, 16'd9),
            mk(8'hF0, -1, 1'b0, 16'd9),
            mk(8'h29, -1, 1'b0, 16'd9),  // E0 F0 29 all consumed
            mk(8'h3A, -1, 1'b1, 16'd9),  // typematic M
            mk(8'h3A, -1, 1'b0, 16'd9),
            mk(8'h55, -1, 1'b0, 16'd9),  // unmapped
            mk(8'hE0, -1, 1'b0, 16'd9),
            mk(8'h34, -1, 1'b0, 16'd9),  // extended G consumed
            mk(8'h34,  0, 1'b0, 16'd9)   // plain G again
        };

        // reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_outputs", all_outputs(), 0);
        check("reset_rx_idle", int'(bus.rx_state), int'(RX_IDLE));
        reset = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        check("post_reset_outputs", all_outputs(), 0);

        // table-driven vectors
        for (int i = 0; i < NV; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].code, 1'b1, 1'b1,
                      vecs[i].exp_pulse, vecs[i].exp_manual, vecs[i].exp_fid);
        end

        // wrong parity on P
`ifdef KBD_PARITY_CHECK_EN
        exp_bad_par = -1;
`else
        exp_bad_par = 1;
`endif
        run_frame("bad_parity_p", 8'h4D, 1'b0, 1'b1, exp_bad_par, 1'b0, 16'd9);

        // stray falling edge with data high: no frame starts
        p0 = pulse_total;
        ps2_bit(1'b1);
        repeat (4) @(posedge clk_in);
        #1;
        check("stray_start_idle", int'(bus.rx_state), int'(RX_IDLE));
        check("stray_start_pulses", pulse_total - p0, 0);
        run_frame("after_stray_c", 8'h21, 1'b1, 1'b1, 2, 1'b0, 16'd9);

        // stop bit 0 discards the frame
        run_frame("bad_stop_g", 8'h34, 1'b1, 1'b0, -1, 1'b0, 16'd9);
        run_frame("after_bad_stop_g", 8'h34, 1'b1, 1'b1, 0, 1'b0, 16'd9);

        // partial frame then timeout
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        #1;
        check("partial_in_progress", int'(bus.rx_state), int'(RX_DATA));
        repeat (TB_TIMEOUT + 1) @(posedge clk_in);
        #1;
        check("timeout_rx_idle", int'(bus.rx_state), int'(RX_IDLE));
        run_frame("after_timeout_c", 8'h21, 1'b1, 1'b1, 2, 1'b0, 16'd9);

        // reset mid-frame
        run_frame("pre_reset_m", 8'h3A, 1'b1, 1'b1, -1, 1'b1, 16'd9);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        @(negedge clk_in);
        reset = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("mid_reset_outputs", all_outputs(), 0);
        check("mid_reset_rx_idle", int'(bus.rx_state), int'(RX_IDLE));
        @(negedge clk_in);
        reset = 1'b0;
        run_frame("after_reset_space", 8'h29, 1'b1, 1'b1, 7, 1'b0, 16'd0);

        // random codes against the reference model
        m_brk = 1'b0; m_ext = 1'b0; m_manual = 1'b0; m_fid = 16'd0;
        for (int i = 0; i < NRAND; i++) begin
            c   = pool[$urandom_range(21, 0)];
            act = model_step(c);
            run_frame($sformatf("rand%0d_%02h", i, c), c, 1'b1, 1'b1, act, m_manual, m_fid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/key_board_controller.md
KEY_BOARD_CONTROLLER -- requirements
Module: key_board_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all logic SHALL be clocked on the rising edge of clk_in.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clk_in cycles of ps2_clock inactivity after which a partial frame is discarded.
REQ-003 clk_in  input  1  system clock, 50 MHz nominal.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 ps2_clock  input  1  asynchronous PS/2 clock from the keyboard.
REQ-006 ps2_data  input  1  asynchronous PS/2 data from the keyboard.
REQ-007 start  output  1  one-cycle pulse on a G make code (0x34).
REQ-008 pause  output  1  one-cycle pulse on a P make code (0x4D).
REQ-009 clear  output  1  one-cycle pulse on a C make code (0x21).
REQ-010 manual  output  1  level; toggles on each M make code (0x3A).
REQ-011 setting  output  4  one-hot one-cycle pulse: bit0 = A (0x1C), bit1 = W (0x1D), bit2 = S (0x1B), bit3 = D (0x23).
REQ-012 modify  output  1  one-cycle pulse on a Space make code (0x29).
REQ-013 file_id  output  16  level; holds the value of the last digit key 0-9.

Function
REQ-014 ps2_clock and ps2_data SHALL each pass through a two-flop synchronizer; a falling edge is detected from the synchronized ps2_clock.
REQ-015 Frame format: 11 bits sampled on falling edges: start bit = 0, 8 data bits LSB first, odd parity, stop bit = 1.
REQ-016 A start bit sampled as 1 SHALL be ignored, and the receiver SHALL stay idle.
REQ-017 A stop bit sampled as 0 SHALL discard the frame.
REQ-018 If no falling edge occurs for TIMEOUT_CYCLES during a partial frame, the bit counter SHALL return to idle and the frame SHALL be discarded.
REQ-019 When a valid frame completes, the receiver SHALL assert an internal code-valid strobe for exactly one cycle after the stop-bit edge is detected, carrying the 8-bit code.
REQ-020 Decoded outputs SHALL be registered and SHALL assert on the cycle after the code-valid strobe; every pulse output SHALL be exactly one clk_in cycle wide.
REQ-021 Code 0xF0 (break prefix) SHALL cause the next code to be consumed without any action.
REQ-022 Code 0xE0 (extended prefix) SHALL cause the next code, including any break sequence that follows, to be consumed without any action.
REQ-023 Digit make codes SHALL load file_id with the zero-extended digit value: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
REQ-024 Unmapped codes SHALL be ignored.
REQ-025 At most one pulse output SHALL be asserted in any cycle.
REQ-026 Typematic repeats (repeated make codes without a break) SHALL each produce a new pulse; for M, each repeat toggles manual again.

Reset
REQ-027 While reset is high, the following SHALL be 0: start, pause, clear, manual, setting, modify, file_id.
REQ-028 While reset is high, the receiver SHALL be idle, and the break and extended flags and the timeout counter SHALL be cleared.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame.

Configuration
REQ-030 When KBD_PARITY_CHECK_EN is defined, frames with a parity error SHALL be discarded.
REQ-031 When KBD_PARITY_CHECK_EN is undefined, the parity bit SHALL be sampled and ignored.

Structure
REQ-032 Package kbd_pkg SHALL hold the scan-code constants: 0xF0, 0xE0, the key codes and the digit codes.
REQ-033 Sub-module ps2_rx SHALL contain the synchronizer, the frame receiver, the timeout and the code-valid strobe; key_board_controller SHALL contain the prefix tracking and the decode.

Verification
REQ-034 Frame 0x34 with correct parity -> start high for exactly 1 cycle; no other output changes.
REQ-035 Sequence 0x3A, F0 3A, 0x3A -> manual goes 0 -> 1 -> 1 (unchanged by the break) -> 0.
REQ-036 Sequence 0x1D then F0 1D -> setting = 4'b0010 for 1 cycle, then no pulse for the break.
REQ-037 Digit 0x26 then E0 26 -> file_id = 3, and it stays 3.
REQ-038 Frame 0x4D with a wrong parity bit -> no pause pulse when KBD_PARITY_CHECK_EN is defined; one pause pulse when it is undefined.
REQ-039 6 bits of a frame, then idle for TIMEOUT_CYCLES+1, then a full 0x21 frame -> exactly one clear pulse.
